// File: rtl/cc_miss_request_unit_if.sv
// cc_miss_request_unit_if: miss-request, AXI AR, R-monitor and miss-address FIFO signals.
interface cc_miss_request_unit_if;
  logic        miss_i;
  logic [31:0] miss_addr_i;
  logic        miss_ready_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  modport slave (
    input  miss_i, miss_addr_i, mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i,
           miss_addr_fifo_full_i,
    output miss_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
           miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o
  );
  modport master (
    output miss_i, miss_addr_i, mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i,
           miss_addr_fifo_full_i,
    input  miss_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
           miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o
  );
endinterface

// File: rtl/cc_miss_request_unit.sv
// cc_miss_request_unit: turns cache misses into 64 B WRAP AXI read bursts, limits outstanding bursts.
module cc_miss_request_unit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                    clk,
  input logic                    rst,
  cc_miss_request_unit_if.slave  bus
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        hs, rdone, accept;
  assign bus.miss_ready_o  = state_q == IDLE && cnt_q < 4'(MAX_OUTSTANDING) && !bus.miss_addr_fifo_full_i;
  assign bus.mem_arvalid_o = state_q == ISSUE;
  assign bus.mem_araddr_o  = {addr_q[31:3], 3'b000};
  assign bus.mem_arlen_o   = 4'd7;
  assign bus.mem_arsize_o  = 3'b011;
  assign bus.mem_arburst_o = 2'b10;
  assign hs     = bus.mem_arvalid_o && bus.mem_arready_i;
  assign rdone  = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;
  assign accept = bus.miss_i && bus.miss_ready_o;
  assign bus.miss_addr_fifo_wren_o  = hs;
  assign bus.miss_addr_fifo_wdata_o = addr_q;
  // a completion at zero outstanding is a protocol error and is dropped
  assign cnt_d = hs && !rdone ? cnt_q + 4'd1 :
                 rdone && !hs && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        addr_q  <= bus.miss_addr_i;
        state_q <= ISSUE;
      end else if (hs) begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_cc_miss_request_unit.sv
// tb_cc_miss_request_unit: randomized and directed checks against a behavioural model.
module tb_cc_miss_request_unit;
  localparam int MAXO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bit busy = 0;
  logic [31:0] pend = '0;
  int outs = 0;
  int n_push = 0;
  cc_miss_request_unit_if bus ();
  cc_miss_request_unit #(.MAX_OUTSTANDING(MAXO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit ar);
    bit rdy;
    rdy = !busy && outs < MAXO && !bus.miss_addr_fifo_full_i;
    chk("miss_ready", 32'(bus.miss_ready_o), 32'(rdy));
    chk("arvalid", 32'(bus.mem_arvalid_o), 32'(busy));
    if (busy) chk("araddr", bus.mem_araddr_o, pend & ~32'h7);
    chk("wren", 32'(bus.miss_addr_fifo_wren_o), 32'(busy && ar));
    if (busy && ar) chk("wdata", bus.miss_addr_fifo_wdata_o, pend);
    chk("arlen", 32'(bus.mem_arlen_o), 32'd7);
    chk("arsize", 32'(bus.mem_arsize_o), 32'd3);
    chk("arburst", 32'(bus.mem_arburst_o), 32'd2);
  endtask

  // called just after a falling edge; drives, checks, steps the model across the rising edge
  task automatic cycle(input bit m, input logic [31:0] a, input bit ar, input bit rv, input bit rr,
                       input bit rl, input bit full);
    bit rdy, hs, rd;
    bus.miss_i = m; bus.miss_addr_i = a; bus.mem_arready_i = ar;
    bus.mem_rvalid_i = rv; bus.mem_rready_i = rr; bus.mem_rlast_i = rl;
    bus.miss_addr_fifo_full_i = full;
    #1;
    check_outputs(ar);
    rdy = !busy && outs < MAXO && !full;
    hs = busy && ar;
    rd = rv && rr && rl;
    @(posedge clk);
    if (hs) begin busy = 0; n_push++; end
    else if (m && rdy) begin busy = 1; pend = a; end
    if (hs && !rd) outs++;
    else if (rd && !hs && outs > 0) outs--;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.miss_i = 0; bus.miss_addr_i = '0; bus.mem_arready_i = 0;
    bus.mem_rvalid_i = 0; bus.mem_rready_i = 0; bus.mem_rlast_i = 0;
    bus.miss_addr_fifo_full_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 32'(bus.mem_arvalid_o), 32'd0);
    chk("rst_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
    chk("rst_araddr", bus.mem_araddr_o, 32'd0);
    chk("rst_wdata", bus.miss_addr_fifo_wdata_o, 32'd0);
    rst = 0;
    #1 chk("rst_ready", 32'(bus.miss_ready_o), 32'd1);
    @(negedge clk);
    // single miss, arready after 3 cycles of arvalid
    cycle(1, 32'h1234_5678, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 32'h0, 0, 0, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0, 0, 0);
    chk("single_outs", 32'(outs), 32'd1);
    cycle(0, 32'h0, 0, 1, 1, 1, 0);
    // rlast beats at zero outstanding must not underflow
    repeat (3) cycle(0, 32'h0, 0, 1, 1, 1, 0);
    cycle(0, 32'h0, 0, 1, 1, 0, 0);
    // four back-to-back misses fill the budget, one completion reopens it
    for (int i = 0; i < 10; i++) cycle(1, 32'h4000_0000 + 32'(i * 64 + 13), 1, 0, 0, 0, 0);
    chk("b2b_outs", 32'(outs), 32'd4);
    cycle(1, 32'h5555_5555, 1, 1, 1, 1, 0);
    cycle(1, 32'h5555_5555, 1, 0, 0, 0, 0);
    // handshake and completion in the same cycle
    repeat (3) cycle(0, 32'h0, 0, 1, 1, 1, 0);
    cycle(1, 32'hA0, 1, 0, 0, 0, 0); cycle(0, 32'h0, 1, 0, 0, 0, 0);
    cycle(1, 32'hB8, 1, 0, 0, 0, 0); cycle(0, 32'h0, 1, 0, 0, 0, 0);
    cycle(1, 32'hC0, 0, 0, 0, 0, 0); cycle(0, 32'h0, 1, 1, 1, 1, 0);
    chk("same_cycle_outs", 32'(outs), 32'd2);
    // full FIFO blocks acceptance; full rising in ISSUE does not cancel
    repeat (3) cycle(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
    cycle(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0, 1);
    cycle(0, 32'h0, 1, 0, 0, 0, 1);
    // asynchronous reset in ISSUE
    repeat (4) cycle(0, 32'h0, 0, 1, 1, 1, 0);
    cycle(1, 32'h8765_4321, 0, 0, 0, 0, 0);
    chk("pre_rst_arvalid", 32'(bus.mem_arvalid_o), 32'd1);
    bus.mem_arready_i = 1;
    #2 rst = 1;
    #1;
    chk("async_arvalid", 32'(bus.mem_arvalid_o), 32'd0);
    chk("async_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
    chk("async_araddr", bus.mem_araddr_o, 32'd0);
    busy = 0; pend = '0; outs = 0;
    @(negedge clk);
    rst = 0;
    idle_cycle();
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0);
    chk("push_count_nonzero", 32'(n_push > 100), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cc_miss_request_unit.md
CC_MISS_REQUEST_UNIT -- requirements
Module: cc_miss_request_unit

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of AXI read bursts issued but not yet completed (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port miss_i  input  1  miss request from tag comparator.
REQ-005 SHALL have port miss_addr_i  input  32  byte address of the missing access.
REQ-006 SHALL have port miss_ready_o  output  1  unit can accept a miss this cycle.
REQ-007 SHALL have port mem_arvalid_o  output  1  AXI AR valid.
REQ-008 SHALL have port mem_arready_i  input  1  AXI AR ready.
REQ-009 SHALL have port mem_araddr_o  output  32  AXI AR address.
REQ-010 SHALL have port mem_arlen_o  output  4  AXI AR burst length.
REQ-011 SHALL have port mem_arsize_o  output  3  AXI AR beat size.
REQ-012 SHALL have port mem_arburst_o  output  2  AXI AR burst type.
REQ-013 SHALL have port mem_rvalid_i, mem_rready_i, mem_rlast_i  input  1 each  R-channel monitor (observed only, never driven).
REQ-014 SHALL have port miss_addr_fifo_full_i  input  1  miss address FIFO full.
REQ-015 SHALL have port miss_addr_fifo_wren_o  output  1  miss address FIFO push.
REQ-016 SHALL have port miss_addr_fifo_wdata_o  output  32  miss address pushed.

Function
REQ-017 SHALL drive constants mem_arlen_o=4'd7, mem_arsize_o=3'b011, mem_arburst_o=2'b10 (WRAP: 8 beats x 8 B = one 64 B line, critical word first).
REQ-018 SHALL implement FSM states IDLE and ISSUE.
REQ-019 IDLE: miss_ready_o=1 iff outstanding count < MAX_OUTSTANDING and miss_addr_fifo_full_i=0; else 0. In ISSUE, miss_ready_o=0.
REQ-020 IDLE with miss_i=1 and miss_ready_o=1: SHALL register miss_addr_i and move to ISSUE next cycle; miss_i with miss_ready_o=0 SHALL be ignored (requester holds it).
REQ-021 ISSUE: SHALL assert mem_arvalid_o=1 with mem_araddr_o={addr[31:3],3'b000}; address and valid SHALL hold stable until mem_arready_i=1.
REQ-022 On the AR handshake cycle (arvalid & arready) SHALL pulse miss_addr_fifo_wren_o=1 for exactly that cycle with miss_addr_fifo_wdata_o = full registered address (bits [5:3] intact, for fill-unit word offset), and return to IDLE next cycle.
REQ-023 miss_addr_fifo_wren_o SHALL never assert outside an AR handshake; exactly one push per issued burst.
REQ-024 Outstanding counter SHALL be 4 bits: +1 on AR handshake, -1 on mem_rvalid_i & mem_rready_i & mem_rlast_i, unchanged when both occur in the same cycle.
REQ-025 Counter SHALL NOT wrap: decrement at 0 ignored (protocol error), increment only possible below MAX_OUTSTANDING by REQ-019.
REQ-026 Back-to-back: earliest next AR handshake SHALL be 2 cycles after the previous one (IDLE accept, ISSUE handshake).
REQ-027 FIFO full rising while in ISSUE SHALL NOT cancel the pending request (entry space was checked at acceptance; this unit is the sole FIFO writer).
REQ-028 R beats without rlast SHALL not affect any state.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force: state IDLE, outstanding=0, mem_arvalid_o=0, miss_addr_fifo_wren_o=0, mem_araddr_o=0, miss_addr_fifo_wdata_o=0, registered address=0; miss_ready_o=1 while rst=0, FIFO not full.
REQ-030 Reset asserted in ISSUE SHALL drop mem_arvalid_o in the same cycle with no FIFO push; the pending miss is discarded.

Verification
REQ-031 Single miss 0x1234_5678, arready=1 after 3 cycles -> araddr=0x1234_5678, arvalid held 3 cycles, one wren with wdata=0x1234_5678, outstanding=1.
REQ-032 Four misses, arready tied 1, no R traffic -> 4 handshakes 2 cycles apart, then miss_ready_o=0; one rlast beat -> miss_ready_o=1 next cycle.
REQ-033 AR handshake and rvalid&rready&rlast same cycle at outstanding=2 -> outstanding stays 2.
REQ-034 miss_addr_fifo_full_i=1 in IDLE with miss_i=1 -> miss_ready_o=0, no AR, no push; full deasserts -> request accepted.
REQ-035 rst asserted mid-ISSUE -> arvalid=0 asynchronously, no push, outstanding=0, IDLE after release.
REQ-036 rlast beats with outstanding=0 -> counter stays 0, no outputs change.
